q_max_finder: RTL and testbench



---
 rtl/q_max_finder.sv | 131 +++++++++++++
 tb/tb_q_max_finder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/q_max_finder.sv
// q_max_finder: scans the legal actions of one board state in the Q-table and
// returns the signed maximum Q value and the lowest action index that reaches it.
// A request takes 11 cycles from accepted start to the one-cycle done pulse.
module q_max_finder #(
    parameter int DATA_W  = 16,
    parameter int STATE_W = 15,
    parameter int ACT_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [STATE_W-1:0]       state_idx,
    input  logic [8:0]               legal_mask,
    output logic                     q_rd_en,
    output logic [STATE_W+ACT_W-1:0] q_rd_addr,
    input  logic [DATA_W-1:0]        q_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        max_q,
    output logic [ACT_W-1:0]         best_action,
    output logic                     no_legal
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} fsm_t;

    localparam logic [ACT_W-1:0] LAST_ACT = ACT_W'(8);
    localparam logic [ACT_W-1:0] NO_ACT   = '1;

    fsm_t               fsm;
    logic [STATE_W-1:0] state_reg;
    // Legal bits of the actions not yet issued; bit 0 belongs to action+1.
    logic [7:0]         legal_reg;
    logic [ACT_W-1:0]   action;

    // Tags travelling alongside each read, aligned with q_rd_data.
    logic               rd_vld;
    logic [ACT_W-1:0]   rd_act;

    logic               found;
    logic [DATA_W-1:0]  max_reg;
    logic [ACT_W-1:0]   arg_reg;

    logic               cmp_found;
    logic [DATA_W-1:0]  cmp_max;
    logic [ACT_W-1:0]   cmp_arg;

    // Running max/argmax after folding in the read that returns this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        cmp_found = found;
        cmp_max   = max_reg;
        cmp_arg   = arg_reg;
        // Strict greater-than keeps the lowest action index on ties.
        if (rd_vld && (!found || ($signed(q_rd_data) > $signed(max_reg)))) begin
            cmp_found = 1'b1;
            cmp_max   = q_rd_data;
            cmp_arg   = rd_act;
        end
    end

    // Control FSM, read issue, read-tag pipeline and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            state_reg   <= '0;
            legal_reg   <= '0;
            action      <= '0;
            rd_vld      <= 1'b0;
            rd_act      <= '0;
            found       <= 1'b0;
            max_reg     <= '0;
            arg_reg     <= '0;
            q_rd_en     <= 1'b0;
            q_rd_addr   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            max_q       <= '0;
            best_action <= NO_ACT;
            no_legal    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
            rd_vld  <= q_rd_en;
            rd_act  <= action;
            found   <= cmp_found;
            max_reg <= cmp_max;
            arg_reg <= cmp_arg;
            done    <= 1'b0;

            case (fsm)
                IDLE: begin
                    if (start) begin
                        state_reg <= state_idx;
                        legal_reg <= legal_mask[8:1];
                        found     <= 1'b0;
                        action    <= '0;
                        q_rd_addr <= {state_idx, ACT_W'(0)};
                        q_rd_en   <= legal_mask[0];
                        busy      <= 1'b1;
                        fsm       <= SCAN;
                    end
                end
                SCAN: begin
                    if (action == LAST_ACT) begin
                        q_rd_en <= 1'b0;
                        fsm     <= DRAIN;
                    end else begin
                        action    <= action + 1'b1;
                        q_rd_addr <= {state_reg, action + 1'b1};
                        q_rd_en   <= legal_reg[0];
                        legal_reg <= {1'b0, legal_reg[7:1]};
                    end
                end
                DRAIN: begin
                    // The last read is folded in via cmp_* in this same edge.
                    done        <= 1'b1;
                    max_q       <= cmp_found ? cmp_max : '0;
                    best_action <= cmp_found ? cmp_arg : NO_ACT;
                    no_legal    <= !cmp_found;
                    fsm         <= DONE;
                end
                DONE: begin
                    busy   <= 1'b0;
                    action <= '0;
                    fsm    <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_max_finder.sv
// Testbench for q_max_finder: directed requests against a Q-table model, a
// cycle-by-cycle compare process against a request-level model, and literal
// expectations for each directed scenario.
module tb_q_max_finder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [14:0] state_idx;
    logic [8:0]  legal_mask;
    logic        q_rd_en;
    logic [18:0] q_rd_addr;
    logic [15:0] q_rd_data;
    logic        busy;
    logic        done;
    logic [15:0] max_q;
    logic [3:0]  best_action;
    logic        no_legal;

    int n_vec  = 0;
    int n_fail = 0;

    // Q-table contents for the state under test; other addresses return junk.
    logic [15:0] qv [9];
    logic [14:0] cur_st;

    q_max_finder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .state_idx   (state_idx),
        .legal_mask  (legal_mask),
        .q_rd_en     (q_rd_en),
        .q_rd_addr   (q_rd_addr),
        .q_rd_data   (q_rd_data),
        .busy        (busy),
        .done        (done),
        .max_q       (max_q),
        .best_action (best_action),
        .no_legal    (no_legal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency Q-table; non-enabled or foreign reads return 16'h7FFF
    // so a compare on an unissued read would corrupt the result.
    always @(posedge clk) begin
        if (q_rd_en && q_rd_addr[18:4] == cur_st && q_rd_addr[3:0] < 4'd9)
            q_rd_data <= qv[q_rd_addr[3:0]];
        else
            q_rd_data <= 16'h7FFF;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- request-level model ----------------
    int          m_cnt = 0;      // 0 = idle, k = k-th cycle after the accepting edge
    logic [8:0]  m_mask = '0;
    logic [14:0] m_st = '0;
    logic [15:0] r_max = '0;     // result of the in-flight request
    logic [3:0]  r_best = 4'hF;
    logic        r_nl = 1'b0;
    logic [15:0] e_max = '0;     // held outputs
    logic [3:0]  e_best = 4'hF;
    logic        e_nl = 1'b0;

    // Maximum over the legal entries, earliest index wins ties.
    task automatic compute(input logic [8:0] m, output logic [15:0] mx,
                           output logic [3:0] bst, output logic nl);
        bit f = 0;
        mx = '0; bst = 4'hF;
        for (int a = 0; a < 9; a++) begin
            if (m[a] && (!f || $signed(qv[a]) > $signed(mx))) begin
                mx = qv[a]; bst = 4'(a); f = 1;
            end
        end
        nl = !f;
        if (!f) mx = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            e_max = '0; e_best = 4'hF; e_nl = 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  = 1;
                m_mask = legal_mask;
                m_st   = state_idx;
                compute(legal_mask, r_max, r_best, r_nl);
            end
        end else begin
            m_cnt = (m_cnt == 11) ? 0 : m_cnt + 1;
            if (m_cnt == 11) begin
                e_max = r_max; e_best = r_best; e_nl = r_nl;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic exp_en;
        exp_en = (m_cnt >= 1 && m_cnt <= 9) ? m_mask[m_cnt-1] : 1'b0;
        check("busy",        32'(busy),        32'(m_cnt != 0));
        check("done",        32'(done),        32'(m_cnt == 11));
        check("q_rd_en",     32'(q_rd_en),     32'(exp_en));
        if (exp_en)
            check("q_rd_addr", 32'(q_rd_addr), 32'({m_st, 4'(m_cnt - 1)}));
        check("max_q",       32'(max_q),       32'(e_max));
        check("best_action", 32'(best_action), 32'(e_best));
        check("no_legal",    32'(no_legal),    32'(e_nl));
    end

    // ---------------- stimulus ----------------
    // Issue one request and count cycles until done (cycle T = start cycle).
    task automatic run_req(input logic [14:0] st, input logic [8:0] mask, output int lat);
        @(posedge clk); #2;
        start = 1'b1; state_idx = st; legal_mask = mask; cur_st = st;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done) break;
        end
        check("latency", 32'(lat), 32'd11);
    endtask

    task automatic check_result(input string tag, input logic [15:0] mx,
                                input logic [3:0] bst, input logic nl);
        check({tag, "_max"},  32'(max_q),       32'(mx));
        check({tag, "_best"}, 32'(best_action), 32'(bst));
        check({tag, "_nl"},   32'(no_legal),    32'(nl));
    endtask

    initial begin
        int lat;
        int ndone;
        rst_n = 1'b1; start = 1'b0; state_idx = '0; legal_mask = '0; cur_st = '0;
        for (int a = 0; a < 9; a++) qv[a] = '0;
        #1 rst_n = 1'b0;
        #1 check_result("rst", 16'h0000, 4'hF, 1'b0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_en",   32'(q_rd_en), 32'd0);
        check("rst_addr", 32'(q_rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Full mask, ascending values.
        for (int a = 0; a < 9; a++) qv[a] = 16'(a * 16);
        run_req(15'h1234, 9'h1FF, lat);
        check_result("full", 16'd128, 4'd8, 1'b0);

        // All negative, one less negative.
        for (int a = 0; a < 9; a++) qv[a] = 16'hFFFB;
        qv[4] = 16'hFFFE;
        run_req(15'h4CE3, 9'h1FF, lat);
        check_result("neg", 16'hFFFE, 4'd4, 1'b0);

        // Sparse mask with a tie and a large illegal entry.
        for (int a = 0; a < 9; a++) qv[a] = 16'd50;
        qv[0] = 16'd1000; qv[2] = 16'd300; qv[4] = 16'd100; qv[8] = 16'd300;
        run_req(15'h0007, 9'b100010100, lat);
        check_result("sparse", 16'd300, 4'd2, 1'b0);

        // Empty mask.
        run_req(15'h7FFF, 9'h000, lat);
        check_result("empty", 16'h0000, 4'hF, 1'b1);

        // Most negative everywhere: first legal action must still be taken.
        for (int a = 0; a < 9; a++) qv[a] = 16'h8000;
        run_req(15'h2AAA, 9'h1FE, lat);
        check_result("minneg", 16'h8000, 4'd1, 1'b0);

        // Reset during scan, at cycle T+5.
        for (int a = 0; a < 9; a++) qv[a] = 16'(100 + a);
        @(posedge clk); #2;
        start = 1'b1; state_idx = 15'h0555; legal_mask = 9'h1FF; cur_st = 15'h0555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1 check_result("midrst", 16'h0000, 4'hF, 1'b0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_en",   32'(q_rd_en), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1; if (done) ndone++;
        end
        check("midrst_nodone", 32'(ndone), 32'd0);
        run_req(15'h0555, 9'h1FF, lat);
        check_result("after_rst", 16'd108, 4'd8, 1'b0);

        // Start held high: accepted once every 12 cycles.
        for (int a = 0; a < 9; a++) qv[a] = 16'(a * 3);
        qv[5] = 16'd77;
        @(posedge clk); #2;
        start = 1'b1; state_idx = 15'h0100; legal_mask = 9'h03F; cur_st = 15'h0100;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1; if (done) ndone++;
        end
        check("held_dones", 32'(ndone), 32'd3);
        check_result("held", 16'd77, 4'd5, 1'b0);
        start = 1'b0;
        lat = 0;
        while (busy && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("held_idle", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
